// File: rtl/systolic_scheduler_v2.sv
// Control sequencer for a ROWS x COLS weight-stationary systolic array:
// weight load, staggered compute with activation feed, drain, done pulse.
module systolic_scheduler_v2 #(
  parameter int ROWS        = 2,
  parameter int COLS        = 2,
  parameter int PE_LATENCY  = 4,
  parameter int MAX_VECTORS = 16,
  parameter int LOAD_ALL    = 0,
  parameter int VEC_W       = $clog2(MAX_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             general_enable,
  input  logic             start,
  input  logic [VEC_W-1:0] num_vectors,
  output logic [ROWS-1:0]  load_weight,
  output logic [ROWS-1:0]  enable_mult,
  output logic             feed_strobe,
  output logic [VEC_W-1:0] feed_index,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2((MAX_VECTORS + ROWS + COLS - 2) * PE_LATENCY + 1);
  localparam int LW = $clog2(ROWS + 1);
  localparam int PW = $clog2(PE_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    ld_q, ld_d;
  logic [CW-1:0]    c_q, c_d;
  logic [CW-1:0]    vidx_q, vidx_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [VEC_W-1:0] nv_q, nv_d;
  logic [CW-1:0]    t_last;

  logic [ROWS-1:0]  lw_d, en_d;
  logic             fs_d, busy_d, done_d;
  logic [VEC_W-1:0] fi_d;

  // Outputs are derived from the next state/counters so the registered
  // outputs line up with the state they describe, with no extra cycle.
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    c_d     = c_q;
    vidx_d  = vidx_q;
    ph_d    = ph_q;
    nv_d    = nv_q;
    t_last  = (CW'(nv_q) + CW'(ROWS + COLS - 2)) * CW'(PE_LATENCY) - CW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ld_d    = '0;
          nv_d    = (num_vectors > VEC_W'(MAX_VECTORS)) ? VEC_W'(MAX_VECTORS) : num_vectors;
        end
      end
      S_LOAD: begin
        if (ld_q == LW'(ROWS - 1)) begin
          c_d     = '0;
          ph_d    = '0;
          vidx_d  = '0;
          state_d = (nv_q != '0) ? S_COMPUTE : S_DONE;
        end else begin
          ld_d = ld_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (c_q == t_last) begin
          state_d = S_DONE;
        end else begin
          c_d = c_q + 1'b1;
          // Phase/vector-index pair replaces c mod / div PE_LATENCY.
          if (ph_q == PW'(PE_LATENCY - 1)) begin
            ph_d   = '0;
            vidx_d = vidx_q + 1'b1;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    lw_d   = '0;
    if (state_d == S_LOAD) begin
      if (LOAD_ALL != 0) lw_d = '1;
      else               lw_d = ROWS'(1) << ld_d;
    end
    en_d = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      en_d[r] = (state_d == S_COMPUTE) && (c_d >= CW'(r * PE_LATENCY));
    end
    fs_d = (state_d == S_COMPUTE) && (ph_d == '0) && (vidx_d < CW'(nv_d));
    fi_d = fs_d ? VEC_W'(vidx_d) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ld_q        <= '0;
      c_q         <= '0;
      vidx_q      <= '0;
      ph_q        <= '0;
      nv_q        <= '0;
      load_weight <= '0;
      enable_mult <= '0;
      feed_strobe <= 1'b0;
      feed_index  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (general_enable) begin
      state_q     <= state_d;
      ld_q        <= ld_d;
      c_q         <= c_d;
      vidx_q      <= vidx_d;
      ph_q        <= ph_d;
      nv_q        <= nv_d;
      load_weight <= lw_d;
      enable_mult <= en_d;
      feed_strobe <= fs_d;
      feed_index  <= fi_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule
